// File: rtl/dma_host_pkg.sv
// Shared command codes, register map, bit positions and FSM encoding for the
// host-side DMA register initiator.
package dma_host_pkg;

    localparam int unsigned PADD_W = 24;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 10;

    localparam logic [CMD_W-1:0] CMD_IDLE = 3'b000;
    localparam logic [CMD_W-1:0] CMD_RD   = 3'b001;
    localparam logic [CMD_W-1:0] CMD_WR   = 3'b010;

    localparam logic [2:0] OFF_STAT  = 3'd0;
    localparam logic [2:0] OFF_RADDR = 3'd1;
    localparam logic [2:0] OFF_WADDR = 3'd2;
    localparam logic [2:0] OFF_LEN   = 3'd3;
    localparam logic [2:0] OFF_CTRL  = 3'd6;

    localparam logic [PADD_W-1:0] DMA_BASE = 24'h080000;

    localparam int unsigned ST_DONE = 0;
    localparam int unsigned ST_BUSY = 1;
    localparam int unsigned ST_REOP = 2;
    localparam int unsigned ST_WEOP = 3;
    localparam int unsigned ST_LEN  = 4;

    localparam int unsigned CT_BYTE = 0;
    localparam int unsigned CT_HW   = 1;
    localparam int unsigned CT_WORD = 2;
    localparam int unsigned CT_GO   = 3;
    localparam int unsigned CT_IEN  = 4;
    localparam int unsigned CT_REEN = 5;
    localparam int unsigned CT_WEEN = 6;
    localparam int unsigned CT_LEEN = 7;
    localparam int unsigned CT_RCON = 8;
    localparam int unsigned CT_WCON = 9;

    typedef enum logic [3:0] {
        S_IDLE, S_W_STAT, S_W_RADDR, S_W_WADDR, S_W_LEN, S_W_CTRL,
        S_R_STAT, S_R_WAIT, S_CAPTURE, S_W_CLR, S_FIN
    } state_e;

    // Control word with the go bit forced to the given value.
    function automatic logic [CTRL_W-1:0] with_go(input logic [CTRL_W-1:0] c, input logic go);
        logic [CTRL_W-1:0] r;
        r        = c;
        r[CT_GO] = go;
        return r;
    endfunction

endpackage

// File: rtl/dma_poll_timer.sv
// Status-poll counter: cleared between sequences, advanced per unfinished poll,
// flags the final permitted poll.
module dma_poll_timer
    import dma_host_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 1024,
    parameter int unsigned POLL_W     = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last_c
);

    logic [POLL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + POLL_W'(1);
        end
    end

    assign last_c = (count == POLL_W'(POLL_LIMIT - 1));

endmodule

// File: rtl/dma_host_cfg_master.sv
// Programs the DMA register block from one start request: clear status, load
// addresses/length/control with go, poll for done or timeout, then drop go.
module dma_host_cfg_master #(
    parameter int unsigned padd_size  = 24,
    parameter int unsigned cmd_size   = 3,
    parameter int unsigned data_size  = 32,
    parameter logic [padd_size-1:0] DMA_BASE = dma_host_pkg::DMA_BASE,
    parameter int unsigned POLL_LIMIT = 1024,
    parameter int unsigned POLL_W     = 11
) (
    input  logic                 clk0,
    input  logic                 reset,
    input  logic                 start,
    input  logic [data_size-1:0] src_addr,
    input  logic [data_size-1:0] dst_addr,
    input  logic [data_size-1:0] xfer_len,
    input  logic [9:0]           ctrl,
    output logic [cmd_size-1:0]  host_cmd,
    output logic [padd_size-1:0] host_addr,
    output logic [data_size-1:0] host_wdata,
    input  logic [data_size-1:0] host_rdata,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 timeout_o,
    output logic [data_size-1:0] status_o
);
    import dma_host_pkg::*;

    state_e               state;
    logic [data_size-1:0] src_q, dst_q, len_q;
    logic [9:0]           ctrl_q;
    logic                 to_flag;
    logic                 req_ok_c, poll_clr_c, poll_inc_c, poll_last_c;

    function automatic logic [padd_size-1:0] reg_addr(input logic [2:0] off);
        return DMA_BASE + padd_size'(off);
    endfunction

    assign req_ok_c   = (xfer_len != '0) && $onehot(ctrl[2:0]);
    assign poll_clr_c = (state == S_IDLE);
    assign poll_inc_c = (state == S_CAPTURE) && !host_rdata[ST_DONE] && !poll_last_c;

    dma_poll_timer #(.POLL_LIMIT(POLL_LIMIT), .POLL_W(POLL_W)) u_poll (
        .clk    (clk0),
        .reset  (reset),
        .clr    (poll_clr_c),
        .inc    (poll_inc_c),
        .last_c (poll_last_c)
    );

    // Bus outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clk0) begin
        if (reset) begin
            state      <= S_IDLE;
            host_cmd   <= cmd_size'(CMD_IDLE);
            host_addr  <= '0;
            host_wdata <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            timeout_o  <= 1'b0;
            status_o   <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            ctrl_q     <= '0;
            to_flag    <= 1'b0;
        end else begin
            host_cmd   <= cmd_size'(CMD_IDLE);
            host_addr  <= '0;
            host_wdata <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            timeout_o  <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    src_q   <= src_addr;
                    dst_q   <= dst_addr;
                    len_q   <= xfer_len;
                    ctrl_q  <= ctrl;
                    to_flag <= 1'b0;
                    busy_o  <= 1'b1;
                    if (req_ok_c) begin
                        state     <= S_W_STAT;
                        host_cmd  <= cmd_size'(CMD_WR);
                        host_addr <= reg_addr(OFF_STAT);
                    end else begin
                        state  <= S_FIN;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end
                end
                S_W_STAT: begin
                    state      <= S_W_RADDR;
                    host_cmd   <= cmd_size'(CMD_WR);
                    host_addr  <= reg_addr(OFF_RADDR);
                    host_wdata <= src_q;
                end
                S_W_RADDR: begin
                    state      <= S_W_WADDR;
                    host_cmd   <= cmd_size'(CMD_WR);
                    host_addr  <= reg_addr(OFF_WADDR);
                    host_wdata <= dst_q;
                end
                S_W_WADDR: begin
                    state      <= S_W_LEN;
                    host_cmd   <= cmd_size'(CMD_WR);
                    host_addr  <= reg_addr(OFF_LEN);
                    host_wdata <= len_q;
                end
                S_W_LEN: begin
                    state      <= S_W_CTRL;
                    host_cmd   <= cmd_size'(CMD_WR);
                    host_addr  <= reg_addr(OFF_CTRL);
                    host_wdata <= data_size'(with_go(ctrl_q, 1'b1));
                end
                S_W_CTRL, S_R_STAT, S_R_WAIT: begin
                    if (state == S_W_CTRL) begin
                        state     <= S_R_STAT;
                        host_cmd  <= cmd_size'(CMD_RD);
                        host_addr <= reg_addr(OFF_STAT);
                    end else begin
                        state <= (state == S_R_STAT) ? S_R_WAIT : S_CAPTURE;
                    end
                end
                // Read data has settled by now; done wins over the last-poll check.
                S_CAPTURE: begin
                    status_o <= host_rdata;
                    if (host_rdata[ST_DONE] || poll_last_c) begin
                        to_flag    <= !host_rdata[ST_DONE];
                        state      <= S_W_CLR;
                        host_cmd   <= cmd_size'(CMD_WR);
                        host_addr  <= reg_addr(OFF_CTRL);
                        host_wdata <= data_size'(with_go(ctrl_q, 1'b0));
                    end else begin
                        state     <= S_R_STAT;
                        host_cmd  <= cmd_size'(CMD_RD);
                        host_addr <= reg_addr(OFF_STAT);
                    end
                end
                S_W_CLR: begin
                    state     <= S_FIN;
                    done_o    <= 1'b1;
                    timeout_o <= to_flag;
                end
                S_FIN: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_host_cfg_master.sv
// Randomized bench: an expected per-cycle bus/flag trace is generated from the
// request at each accepted start and compared with the DUT every cycle.
module tb_dma_host_cfg_master;

    localparam int LIMIT = 4;
    localparam logic [23:0] BASE = 24'h080000;

    logic        clk0 = 1'b0;
    logic        reset, start;
    logic [31:0] src_addr, dst_addr, xfer_len, host_wdata, host_rdata, status_o;
    logic [9:0]  ctrl;
    logic [2:0]  host_cmd;
    logic [23:0] host_addr;
    logic        busy_o, done_o, err_o, timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    dma_host_cfg_master #(.POLL_LIMIT(LIMIT), .POLL_W(3)) dut (
        .clk0(clk0), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .xfer_len(xfer_len), .ctrl(ctrl),
        .host_cmd(host_cmd), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .timeout_o(timeout_o), .status_o(status_o)
    );

    always #5 clk0 = ~clk0;

    typedef struct {
        logic [2:0]  cmd;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic        busy, done, err, tmo;
        logic [31:0] status;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] resp [1:16];
    logic [31:0] exp_status;
    int          done_poll;
    int          cyc_ctr = 0;
    int          rd_idx  = 0;

    logic [55:0] wr_log[$];
    int          wr_cyc[$];
    int          rd_cnt, done_cnt, wstat_cnt, first_done_cyc;
    logic        d_err, d_tmo;
    logic [31:0] d_status;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] wrv(input logic [23:0] a, input logic [31:0] d);
        return 64'({a, d});
    endfunction

    function automatic exp_t mk(input logic [2:0] c, input logic [23:0] a, input logic [31:0] d,
                                input logic b, input logic dn, input logic e, input logic t,
                                input logic [31:0] s);
        exp_t x;
        x.cmd = c; x.addr = a; x.wdata = d; x.busy = b;
        x.done = dn; x.err = e; x.tmo = t; x.status = s;
        return x;
    endfunction

    // Whole expected trace of one accepted request, one entry per cycle.
    function automatic void build();
        int          n;
        logic        ok_poll;
        logic [31:0] s, r, cw;
        if (xfer_len == 32'h0 || !(ctrl[2:0] inside {3'b001, 3'b010, 3'b100})) begin
            q.push_back(mk(3'b000, 24'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, exp_status));
            return;
        end
        ok_poll = (done_poll >= 1 && done_poll <= LIMIT);
        n  = ok_poll ? done_poll : LIMIT;
        s  = exp_status;
        cw = {22'h0, ctrl};
        q.push_back(mk(3'b010, BASE,          32'h0,      1'b1, 1'b0, 1'b0, 1'b0, s));
        q.push_back(mk(3'b010, BASE + 24'd1,  src_addr,   1'b1, 1'b0, 1'b0, 1'b0, s));
        q.push_back(mk(3'b010, BASE + 24'd2,  dst_addr,   1'b1, 1'b0, 1'b0, 1'b0, s));
        q.push_back(mk(3'b010, BASE + 24'd3,  xfer_len,   1'b1, 1'b0, 1'b0, 1'b0, s));
        q.push_back(mk(3'b010, BASE + 24'd6,  cw | 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, s));
        for (int i = 1; i <= n; i++) begin
            r = $urandom;
            r[0] = (i == done_poll);
            resp[i] = r;
            q.push_back(mk(3'b001, BASE,  32'h0, 1'b1, 1'b0, 1'b0, 1'b0, s));
            q.push_back(mk(3'b000, 24'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, s));
            q.push_back(mk(3'b000, 24'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, s));
            s = r;
        end
        q.push_back(mk(3'b010, BASE + 24'd6, cw & ~32'h8, 1'b1, 1'b0, 1'b0, 1'b0, s));
        q.push_back(mk(3'b000, 24'h0, 32'h0, 1'b1, 1'b1, 1'b0, !ok_poll, s));
        exp_status = s;
    endfunction

    // Reference model: advance the expected trace at every edge.
    always @(posedge clk0) begin
        cyc_ctr++;
        if (reset) begin
            q.delete();
            exp_status = 32'h0;
            cur = mk(3'b000, 24'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (!cur.busy && start) begin
            build();
            cur = q.pop_front();
        end else begin
            cur = mk(3'b000, 24'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, exp_status);
        end
    end

    // DMA register block: answers a status read on the edge after the read cmd;
    // between sequences it presents a stale "done" value.
    always @(posedge clk0) begin
        if (busy_o !== 1'b1) begin
            rd_idx = 0;
            host_rdata <= 32'h1;
        end else if (host_cmd == 3'b001) begin
            rd_idx++;
            host_rdata <= resp[rd_idx];
        end
    end

    // Per-cycle compare plus event logging for the directed checks.
    always @(negedge clk0) begin
        chk("host_cmd", 64'(host_cmd), 64'(cur.cmd));
        if (cur.cmd != 3'b000) chk("host_addr", 64'(host_addr), 64'(cur.addr));
        chk("host_wdata", 64'(host_wdata), 64'(cur.wdata));
        chk("busy_o", 64'(busy_o), 64'(cur.busy));
        chk("done_o", 64'(done_o), 64'(cur.done));
        chk("err_o", 64'(err_o), 64'(cur.err));
        chk("timeout_o", 64'(timeout_o), 64'(cur.tmo));
        chk("status_o", 64'(status_o), 64'(cur.status));
        if (host_cmd == 3'b010) begin
            wr_log.push_back({host_addr, host_wdata});
            wr_cyc.push_back(cyc_ctr);
            if (host_addr == BASE) wstat_cnt++;
        end
        if (host_cmd == 3'b001) rd_cnt++;
        if (done_o) begin
            done_cnt++;
            if (done_cnt == 1) begin
                first_done_cyc = cyc_ctr;
                d_err = err_o; d_tmo = timeout_o; d_status = status_o;
            end
        end
    end

    task automatic clear_logs();
        wr_log.delete(); wr_cyc.delete();
        rd_cnt = 0; done_cnt = 0; wstat_cnt = 0; first_done_cyc = -1;
        d_err = 1'bx; d_tmo = 1'bx; d_status = 'x;
    endtask

    task automatic drive_seq(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                             input logic [9:0] c, input int dp, input int hold, output int c0);
        @(posedge clk0); #2;
        src_addr = s; dst_addr = d; xfer_len = l; ctrl = c; done_poll = dp; start = 1'b1;
        clear_logs();
        c0 = cyc_ctr;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk0); #2;
            src_addr = $urandom; dst_addr = $urandom;
        end
        @(posedge clk0); #2;
        start = 1'b0;
        for (int k = 0; k < 400 && busy_o !== 1'b0; k++) begin
            @(posedge clk0); #2;
        end
        chk("idle_wait", 64'(busy_o), 64'h0);
        @(posedge clk0); #2;
    endtask

    initial begin
        int c0;
        logic [9:0]  rc;
        logic [31:0] rl;
        reset = 1'b1; start = 1'b0; src_addr = 0; dst_addr = 0; xfer_len = 0; ctrl = 0;
        done_poll = 0; host_rdata = 32'h1;
        clear_logs();
        repeat (3) @(posedge clk0);
        #2;
        chk("reset_cmd", 64'(host_cmd), 64'h0);
        chk("reset_busy", 64'(busy_o), 64'h0);
        reset = 1'b0;

        // Happy path, done on the second poll.
        drive_seq(32'h100, 32'h200, 32'h40, 10'h004, 2, 1, c0);
        chk("hp_nwr", 64'(wr_log.size()), 64'd6);
        chk("hp_w0", 64'(wr_log[0]), wrv(24'h080000, 32'h0));
        chk("hp_w1", 64'(wr_log[1]), wrv(24'h080001, 32'h100));
        chk("hp_w2", 64'(wr_log[2]), wrv(24'h080002, 32'h200));
        chk("hp_w3", 64'(wr_log[3]), wrv(24'h080003, 32'h40));
        chk("hp_w4", 64'(wr_log[4]), wrv(24'h080006, 32'h00C));
        chk("hp_w5", 64'(wr_log[5]), wrv(24'h080006, 32'h004));
        chk("hp_consec", 64'(wr_cyc[4] - wr_cyc[0]), 64'd4);
        chk("hp_reads", 64'(rd_cnt), 64'd2);
        chk("hp_err", 64'(d_err), 64'h0);
        chk("hp_done_bit", 64'(d_status[0]), 64'h1);

        // Timeout: DMA never reports done.
        drive_seq(32'h1000, 32'h2000, 32'h80, 10'h001, 0, 1, c0);
        chk("to_reads", 64'(rd_cnt), 64'd4);
        chk("to_flag", 64'(d_tmo), 64'h1);
        chk("to_clr", 64'(wr_log[5]), wrv(24'h080006, 32'h001));

        // Rejections.
        drive_seq(32'h1, 32'h2, 32'h0, 10'h004, 1, 1, c0);
        chk("rj0_traffic", 64'(wr_log.size() + rd_cnt), 64'd0);
        chk("rj0_err", 64'(d_err), 64'h1);
        chk("rj0_when", 64'(first_done_cyc), 64'(c0 + 1));
        drive_seq(32'h1, 32'h2, 32'h40, 10'h006, 1, 1, c0);
        chk("rj1_traffic", 64'(wr_log.size() + rd_cnt), 64'd0);
        chk("rj1_err", 64'(d_err), 64'h1);
        chk("rj1_when", 64'(first_done_cyc), 64'(c0 + 1));

        // start held high across a sequence: exactly one back-to-back re-accept.
        drive_seq(32'h300, 32'h400, 32'h10, 10'h002, 1, 15, c0);
        chk("hold_wstat", 64'(wstat_cnt), 64'd2);
        chk("hold_done", 64'(done_cnt), 64'd2);

        // Reset while waiting on read data.
        @(posedge clk0); #2;
        src_addr = 32'h55; dst_addr = 32'h66; xfer_len = 32'h20; ctrl = 10'h004; done_poll = 3;
        start = 1'b1;
        clear_logs();
        @(posedge clk0); #2;
        start = 1'b0;
        for (int k = 0; k < 50 && host_cmd !== 3'b001; k++) begin
            @(posedge clk0); #2;
        end
        chk("rst_reach_rd", 64'(host_cmd), 64'h1);
        @(posedge clk0); #2;
        reset = 1'b1;
        @(posedge clk0); #2;
        reset = 1'b0;
        chk("rst_cmd", 64'(host_cmd), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_status", 64'(status_o), 64'h0);
        repeat (8) @(posedge clk0);
        #2;
        chk("rst_no_clr", 64'(wr_log.size()), 64'd5);

        // Randomized requests, including invalid ones and held starts.
        for (int it = 0; it < 30; it++) begin
            rc = 10'($urandom);
            case ($urandom_range(0, 4))
                0: rc[2:0] = 3'b001;
                1: rc[2:0] = 3'b010;
                2: rc[2:0] = 3'b100;
                default: rc[2:0] = 3'($urandom);
            endcase
            rl = ($urandom_range(0, 6) == 0) ? 32'h0 : $urandom;
            drive_seq($urandom, $urandom, rl, rc, $urandom_range(0, 6),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 1, c0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
